// File: rtl/reg_sched_pkg.sv
// Shared types and size defaults for the register-issue scoreboard.
// Defaults follow PARALLEL_ORDER / REG_ENTRY / REG_ADDR_WIDTH when those global macros are defined.
`ifndef PARALLEL_ORDER
`define PARALLEL_ORDER 4
`endif

`ifndef REG_ENTRY
`define REG_ENTRY 32
`endif

`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif

package reg_sched_pkg;

   localparam int DEF_LANES   = `PARALLEL_ORDER;
   localparam int DEF_ENTRIES = `REG_ENTRY;
   localparam int DEF_AW      = `REG_ADDR_WIDTH;

   // Address fields are sized by the package width, so instances keep AW at DEF_AW.
   typedef struct packed {
      logic              src1_v;
      logic              src2_v;
      logic              dst_v;
      logic [DEF_AW-1:0] src1;
      logic [DEF_AW-1:0] src2;
      logic [DEF_AW-1:0] dst;
   } lane_req_t;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      DONE  = 2'd2
   } sb_state_e;

endpackage

// File: rtl/sb_hazard_check.sv
// Per-lane issue eligibility: RAW/WAW against the busy vector and against
// destinations already claimed by granted lower lanes of the same bundle.
module sb_hazard_check
   import reg_sched_pkg::*;
#(
   parameter int LANES   = DEF_LANES,
   parameter int ENTRIES = DEF_ENTRIES,
   parameter int AW      = DEF_AW
) (
   input  logic                valid,
   input  lane_req_t           req,
   input  logic [ENTRIES-1:0]  busy,
   input  logic [LANES*AW-1:0] lower_dst,
   input  logic [LANES-1:0]    lower_claim,
   output logic                eligible
);

   // Out-of-range addresses match no entry, so they can never hit busy.
   function automatic logic busy_hit(input logic [DEF_AW-1:0] addr,
                                     input logic [ENTRIES-1:0] vec);
      busy_hit = 1'b0;
      for (int e = 0; e < ENTRIES; e++) begin
         if (int'(addr) == e) busy_hit = vec[e];
      end
   endfunction

   logic raw_hit;
   logic waw_hit;
   logic bundle_hit;

   // NOTE: every variable written in always_comb gets a value on every path
   // (defaults first), otherwise synthesis infers a latch.
   always_comb begin
      raw_hit    = (req.src1_v && busy_hit(req.src1, busy)) ||
                   (req.src2_v && busy_hit(req.src2, busy));
      waw_hit    = req.dst_v && busy_hit(req.dst, busy);
      bundle_hit = 1'b0;
      for (int k = 0; k < LANES; k++) begin
         if (lower_claim[k]) begin
            if ((req.src1_v && (req.src1 == lower_dst[k*AW +: AW])) ||
                (req.src2_v && (req.src2 == lower_dst[k*AW +: AW])) ||
                (req.dst_v  && (req.dst  == lower_dst[k*AW +: AW]))) begin
               bundle_hit = 1'b1;
            end
         end
      end
      eligible = valid && !raw_hit && !waw_hit && !bundle_hit;
   end

endmodule

// File: rtl/reg_issue_scoreboard.sv
// In-order multi-lane issue scoreboard with busy tracking and drain handshake.
// Optional stall statistics counter enabled by defining SB_STATS_EN.
module reg_issue_scoreboard
   import reg_sched_pkg::*;
#(
   parameter int LANES   = DEF_LANES,
   parameter int ENTRIES = DEF_ENTRIES,
   parameter int AW      = DEF_AW
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [LANES-1:0]    iss_valid,
   input  logic [LANES-1:0]    iss_src1_v,
   input  logic [LANES-1:0]    iss_src2_v,
   input  logic [LANES-1:0]    iss_dst_v,
   input  logic [LANES*AW-1:0] iss_src1,
   input  logic [LANES*AW-1:0] iss_src2,
   input  logic [LANES*AW-1:0] iss_dst,
   output logic [LANES-1:0]    iss_grant,
   input  logic [LANES-1:0]    wb_valid,
   input  logic [LANES*AW-1:0] wb_addr,
   input  logic                drain_req,
   output logic                drain_done,
   output logic [ENTRIES-1:0]  busy
`ifdef SB_STATS_EN
   ,
   output logic [31:0]         stall_cnt
`endif
);

   sb_state_e          state;
   sb_state_e          state_next;
   logic [ENTRIES-1:0] busy_next;
   logic               issue_en;

   // Grants are suppressed while draining and while reset is held.
   assign issue_en = rst_n && (state == RUN);

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      lane_req_t        req;
      logic [LANES-1:0] lower_claim;
      logic             eligible;
      logic             grant;

      assign req = '{src1_v: iss_src1_v[l],
                     src2_v: iss_src2_v[l],
                     dst_v:  iss_dst_v[l],
                     src1:   iss_src1[l*AW +: AW],
                     src2:   iss_src2[l*AW +: AW],
                     dst:    iss_dst[l*AW +: AW]};

      if (l == 0) begin : g_head
         assign lower_claim = '0;
         assign grant       = eligible && issue_en;
      end else begin : g_tail
         // Accumulate the destinations claimed by granted lanes below this one.
         assign lower_claim = g_lane[l-1].lower_claim |
                              ({{(LANES-1){1'b0}}, g_lane[l-1].grant && iss_dst_v[l-1]} << (l-1));
         assign grant       = eligible && g_lane[l-1].grant;
      end

      sb_hazard_check #(
         .LANES   (LANES),
         .ENTRIES (ENTRIES),
         .AW      (AW)
      ) u_hazard (
         .valid       (iss_valid[l]),
         .req         (req),
         .busy        (busy),
         .lower_dst   (iss_dst),
         .lower_claim (lower_claim),
         .eligible    (eligible)
      );

      assign iss_grant[l] = grant;
   end

   // Clears are applied before sets so a same-cycle set/clear leaves the bit set.
   always_comb begin
      busy_next = busy;
      for (int e = 0; e < ENTRIES; e++) begin
         for (int l = 0; l < LANES; l++) begin
            if (wb_valid[l] && (int'(wb_addr[l*AW +: AW]) == e)) busy_next[e] = 1'b0;
         end
         for (int l = 0; l < LANES; l++) begin
            if (iss_grant[l] && iss_dst_v[l] && (int'(iss_dst[l*AW +: AW]) == e)) begin
               busy_next[e] = 1'b1;
            end
         end
      end
   end

   always_comb begin
      state_next = state;
      unique case (state)
         RUN:     if (drain_req) state_next = DRAIN;
         DRAIN:   if ((busy == '0) && (wb_valid == '0)) state_next = DONE;
         DONE:    state_next = RUN;
         default: state_next = RUN;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values; busy is a flop vector, not a RAM, so it is reset directly.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= RUN;
         busy  <= '0;
      end else begin
         state <= state_next;
         busy  <= busy_next;
      end
   end

   assign drain_done = (state == DONE);

`ifdef SB_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
      end else if ((state == RUN) && ((iss_valid & ~iss_grant) != '0) &&
                   (stall_cnt != 32'hFFFF_FFFF)) begin
         stall_cnt <= stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_reg_issue_scoreboard.sv
// Self-checking bench for reg_issue_scoreboard: vector table, directed
// multi-cycle sequences and a randomized run against a behavioural model.
module tb_reg_issue_scoreboard;

   localparam int LANES   = 4;
   localparam int ENTRIES = 32;
   localparam int AW      = 5;
   localparam int NVEC    = 9;
   localparam int NRAND   = 400;

   logic                clk = 1'b0;
   logic                rst_n;
   logic [LANES-1:0]    iss_valid, iss_src1_v, iss_src2_v, iss_dst_v;
   logic [LANES*AW-1:0] iss_src1, iss_src2, iss_dst;
   logic [LANES-1:0]    iss_grant;
   logic [LANES-1:0]    wb_valid;
   logic [LANES*AW-1:0] wb_addr;
   logic                drain_req;
   logic                drain_done;
   logic [ENTRIES-1:0]  busy;
`ifdef SB_STATS_EN
   logic [31:0]         stall_cnt;
`endif

   int checks   = 0;
   int failures = 0;

   reg_issue_scoreboard #(.LANES(LANES), .ENTRIES(ENTRIES), .AW(AW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .iss_valid  (iss_valid),
      .iss_src1_v (iss_src1_v),
      .iss_src2_v (iss_src2_v),
      .iss_dst_v  (iss_dst_v),
      .iss_src1   (iss_src1),
      .iss_src2   (iss_src2),
      .iss_dst    (iss_dst),
      .iss_grant  (iss_grant),
      .wb_valid   (wb_valid),
      .wb_addr    (wb_addr),
      .drain_req  (drain_req),
      .drain_done (drain_done),
      .busy       (busy)
`ifdef SB_STATS_EN
      ,
      .stall_cnt  (stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [LANES-1:0]    valid;
      logic [LANES-1:0]    s1v;
      logic [LANES-1:0]    s2v;
      logic [LANES-1:0]    dv;
      logic [LANES*AW-1:0] s1;
      logic [LANES*AW-1:0] s2;
      logic [LANES*AW-1:0] d;
      logic [LANES-1:0]    exp_grant;
      logic [ENTRIES-1:0]  exp_busy;
   } vec_t;

   vec_t vec [NVEC];

   // Behavioural model state: 0 = running, 1 = draining, 2 = done pulse.
   bit          m_busy [ENTRIES];
   int          m_mode;
   logic [31:0] m_stall;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic clear_inputs();
      iss_valid = '0; iss_src1_v = '0; iss_src2_v = '0; iss_dst_v = '0;
      iss_src1 = '0; iss_src2 = '0; iss_dst = '0;
      wb_valid = '0; wb_addr = '0; drain_req = 1'b0;
   endtask

   task automatic set_lane(input int l, input logic v,
                           input logic s1v, input logic [AW-1:0] s1,
                           input logic s2v, input logic [AW-1:0] s2,
                           input logic dv,  input logic [AW-1:0] d);
      iss_valid[l] = v; iss_src1_v[l] = s1v; iss_src2_v[l] = s2v; iss_dst_v[l] = dv;
      iss_src1[l*AW +: AW] = s1; iss_src2[l*AW +: AW] = s2; iss_dst[l*AW +: AW] = d;
   endtask

   task automatic set_wb(input int l, input logic [AW-1:0] a);
      wb_valid[l] = 1'b1;
      wb_addr[l*AW +: AW] = a;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst_n = 1'b0;
      next_cycle();
      rst_n = 1'b1;
   endtask

   function automatic logic [LANES-1:0] model_grant();
      logic [LANES-1:0] g = '0;
      int               claimed [$];
      bit               blocked = 0;
      if (m_mode != 0) return '0;
      for (int l = 0; l < LANES; l++) begin
         int  a1 = int'(iss_src1[l*AW +: AW]);
         int  a2 = int'(iss_src2[l*AW +: AW]);
         int  ad = int'(iss_dst[l*AW +: AW]);
         bit  ok = iss_valid[l];
         if (iss_src1_v[l] && m_busy[a1]) ok = 0;
         if (iss_src2_v[l] && m_busy[a2]) ok = 0;
         if (iss_dst_v[l]  && m_busy[ad]) ok = 0;
         foreach (claimed[i]) begin
            if (iss_src1_v[l] && a1 == claimed[i]) ok = 0;
            if (iss_src2_v[l] && a2 == claimed[i]) ok = 0;
            if (iss_dst_v[l]  && ad == claimed[i]) ok = 0;
         end
         if (blocked || !ok) begin
            blocked = 1;
         end else begin
            g[l] = 1'b1;
            if (iss_dst_v[l]) claimed.push_back(ad);
         end
      end
      return g;
   endfunction

   function automatic logic [ENTRIES-1:0] model_busy_vec();
      logic [ENTRIES-1:0] v;
      for (int e = 0; e < ENTRIES; e++) v[e] = m_busy[e];
      return v;
   endfunction

   initial begin
      vec[0] = '{4'hF, 4'h0, 4'h0, 4'hF, 20'h0, 20'h0, {5'd4, 5'd3, 5'd2, 5'd1}, 4'hF, 32'h0000_001E};
      vec[1] = '{4'h7, 4'h2, 4'h0, 4'h7, {5'd0, 5'd0, 5'd5, 5'd0}, 20'h0, {5'd0, 5'd7, 5'd6, 5'd5}, 4'h1, 32'h0000_0020};
      vec[2] = '{4'h3, 4'h0, 4'h0, 4'h3, 20'h0, 20'h0, {5'd0, 5'd0, 5'd8, 5'd8}, 4'h1, 32'h0000_0100};
      vec[3] = '{4'h2, 4'h0, 4'h0, 4'h2, 20'h0, 20'h0, {5'd0, 5'd0, 5'd2, 5'd0}, 4'h0, 32'h0000_0000};
      vec[4] = '{4'h3, 4'h0, 4'h0, 4'h1, {5'd0, 5'd0, 5'd3, 5'd0}, 20'h0, {5'd0, 5'd0, 5'd0, 5'd3}, 4'h3, 32'h0000_0008};
      vec[5] = '{4'h3, 4'h0, 4'h2, 4'h1, 20'h0, {5'd0, 5'd0, 5'd10, 5'd0}, {5'd0, 5'd0, 5'd0, 5'd10}, 4'h1, 32'h0000_0400};
      vec[6] = '{4'h3, 4'h2, 4'h0, 4'h0, {5'd0, 5'd0, 5'd4, 5'd0}, 20'h0, {5'd0, 5'd0, 5'd0, 5'd4}, 4'h3, 32'h0000_0000};
      vec[7] = '{4'hF, 4'h8, 4'h0, 4'h7, {5'd2, 5'd0, 5'd0, 5'd0}, 20'h0, {5'd0, 5'd3, 5'd2, 5'd1}, 4'h7, 32'h0000_000E};
      vec[8] = '{4'h1, 4'h1, 4'h0, 4'h1, {5'd0, 5'd0, 5'd0, 5'd12}, 20'h0, {5'd0, 5'd0, 5'd0, 5'd12}, 4'h1, 32'h0000_1000};

      // Reset state, with every lane requesting while reset is held.
      clear_inputs();
      rst_n = 1'b0;
      for (int l = 0; l < LANES; l++) set_lane(l, 1, 0, 0, 0, 0, 1, AW'(l + 1));
      @(negedge clk);
      check("reset_grant", iss_grant, 4'h0);
      check("reset_busy", busy, 32'h0);
      check("reset_done", drain_done, 1'b0);
`ifdef SB_STATS_EN
      check("reset_stall", stall_cnt, 32'h0);
`endif

      // Single-bundle vectors, each from a clean reset.
      for (int i = 0; i < NVEC; i++) begin
         do_reset();
         iss_valid = vec[i].valid; iss_src1_v = vec[i].s1v; iss_src2_v = vec[i].s2v;
         iss_dst_v = vec[i].dv; iss_src1 = vec[i].s1; iss_src2 = vec[i].s2; iss_dst = vec[i].d;
         @(negedge clk);
         check($sformatf("vec%0d_grant", i), iss_grant, vec[i].exp_grant);
         next_cycle();
         clear_inputs();
         @(negedge clk);
         check($sformatf("vec%0d_busy", i), busy, vec[i].exp_busy);
      end

      // Busy release: no writeback bypass.
      do_reset();
      set_lane(0, 1, 0, 0, 0, 0, 1, 7);
      @(negedge clk); check("rel_issue", iss_grant, 4'h1);
      next_cycle(); clear_inputs();
      set_lane(0, 1, 0, 0, 1, 7, 0, 0);
      @(negedge clk); check("rel_stall", iss_grant, 4'h0);
      check("rel_busy7", busy[7], 1'b1);
      next_cycle();
      set_wb(0, 7);
      @(negedge clk); check("rel_wb_cycle", iss_grant, 4'h0);
      next_cycle();
      wb_valid = '0;
      @(negedge clk); check("rel_after_wb", iss_grant, 4'h1);
      check("rel_busy_clear", busy, 32'h0);

      // Same-cycle set and clear of r9: set wins.
      do_reset();
      set_wb(1, 9);
      set_lane(0, 1, 0, 0, 0, 0, 1, 9);
      @(negedge clk); check("coll_grant", iss_grant, 4'h1);
      next_cycle(); clear_inputs();
      @(negedge clk); check("coll_busy", busy, 32'h0000_0200);
      set_lane(0, 1, 0, 0, 0, 0, 1, 9);
      set_lane(1, 1, 0, 0, 0, 0, 1, 1);
      @(negedge clk); check("waw_busy_inorder", iss_grant, 4'h0);

      // Minimum drain latency with nothing outstanding.
      do_reset();
      drain_req = 1'b1;
      @(negedge clk); check("min_c0_done", drain_done, 1'b0);
      next_cycle(); drain_req = 1'b0;
      @(negedge clk); check("min_c1_done", drain_done, 1'b0);
      next_cycle();
      @(negedge clk); check("min_c2_done", drain_done, 1'b1);
      next_cycle();
      set_lane(0, 1, 0, 0, 0, 0, 1, 15);
      @(negedge clk); check("min_c3_done", drain_done, 1'b0);
      check("min_c3_grant", iss_grant, 4'h1);

      // Drain with r3 outstanding, retired two cycles after drain_req.
      begin
         int pulses = 0;
         do_reset();
         set_lane(0, 1, 0, 0, 0, 0, 1, 3);
         next_cycle(); clear_inputs();
         drain_req = 1'b1;
         @(negedge clk); check("drain_c0_busy", busy, 32'h0000_0008);
         if (drain_done) pulses++;
         next_cycle();
         set_lane(0, 1, 0, 0, 0, 0, 1, 20);
         for (int c = 1; c <= 5; c++) begin
            wb_valid = '0;
            if (c == 2) set_wb(0, 3);
            if (c == 5) drain_req = 1'b0;
            @(negedge clk);
            check($sformatf("drain_c%0d_done", c), drain_done, (c == 4) ? 1'b1 : 1'b0);
            check($sformatf("drain_c%0d_grant", c), iss_grant, (c == 5) ? 4'h1 : 4'h0);
            if (drain_done) pulses++;
            next_cycle();
         end
         check("drain_pulses", pulses, 1);
      end

      // Reset asserted while draining.
      do_reset();
      set_lane(0, 1, 0, 0, 0, 0, 1, 11);
      next_cycle(); clear_inputs();
      drain_req = 1'b1;
      next_cycle(); drain_req = 1'b0;
      set_lane(0, 1, 0, 0, 0, 0, 1, 21);
      @(negedge clk); check("rstd_drain_grant", iss_grant, 4'h0);
      #1 rst_n = 1'b0;
      #1;
      check("rstd_busy", busy, 32'h0);
      check("rstd_grant", iss_grant, 4'h0);
      check("rstd_done", drain_done, 1'b0);
      next_cycle(); rst_n = 1'b1;
      @(negedge clk); check("rstd_resume_grant", iss_grant, 4'h1);
      begin
         int pulses = 0;
         for (int c = 0; c < 4; c++) begin
            if (drain_done) pulses++;
            next_cycle(); clear_inputs();
         end
         check("rstd_no_pulse", pulses, 0);
      end

      // Randomized run against the behavioural model.
      do_reset();
      foreach (m_busy[e]) m_busy[e] = 0;
      m_mode  = 0;
      m_stall = '0;
      for (int cyc = 0; cyc < NRAND; cyc++) begin
         logic [LANES-1:0] g;
         bit               any_busy;
         int               busy_list [$];
         clear_inputs();
         for (int e = 0; e < ENTRIES; e++) if (m_busy[e]) busy_list.push_back(e);
         for (int l = 0; l < LANES; l++) begin
            logic [AW-1:0] a [3];
            for (int j = 0; j < 3; j++)
               a[j] = ($urandom_range(0, 9) == 0) ? AW'($urandom_range(0, ENTRIES - 1))
                                                  : AW'($urandom_range(0, 7));
            set_lane(l, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), a[0],
                     1'($urandom_range(0, 1)), a[1], 1'($urandom_range(0, 1)), a[2]);
            if (busy_list.size() > 0 && $urandom_range(0, 2) == 0)
               set_wb(l, AW'(busy_list[$urandom_range(0, busy_list.size() - 1)]));
         end
         drain_req = ($urandom_range(0, 24) == 0);
         @(negedge clk);
         g = model_grant();
         check($sformatf("rnd%0d_grant", cyc), iss_grant, g);
         check($sformatf("rnd%0d_busy", cyc), busy, model_busy_vec());
         check($sformatf("rnd%0d_done", cyc), drain_done, (m_mode == 2) ? 1'b1 : 1'b0);
`ifdef SB_STATS_EN
         check($sformatf("rnd%0d_stall", cyc), stall_cnt, m_stall);
         if (m_mode == 0 && (iss_valid & ~g) != '0 && m_stall != 32'hFFFF_FFFF) m_stall++;
`endif
         any_busy = 0;
         foreach (m_busy[e]) if (m_busy[e]) any_busy = 1;
         case (m_mode)
            0:       if (drain_req) m_mode = 1;
            1:       if (!any_busy && wb_valid == '0) m_mode = 2;
            default: m_mode = 0;
         endcase
         for (int l = 0; l < LANES; l++)
            if (wb_valid[l]) m_busy[int'(wb_addr[l*AW +: AW])] = 0;
         for (int l = 0; l < LANES; l++)
            if (g[l] && iss_dst_v[l]) m_busy[int'(iss_dst[l*AW +: AW])] = 1;
         next_cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
